// File: rtl/pdua_pkg.sv
// Shared encodings for the PDUA datapath: ALU operations, post-shifter
// controls and register-bank slot assignments.
package pdua_pkg;

    typedef enum logic [2:0] {
        OP_PASSA = 3'b000,
        OP_PASSB = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_ADD   = 3'b101,
        OP_INCB  = 3'b110,
        OP_NOTA  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        SH_NONE    = 2'b00,
        SH_LEFT    = 2'b01,
        SH_RIGHT   = 2'b10,
        SH_SPECIAL = 2'b11
    } shamt_t;

    localparam int REG_PC   = 0;
    localparam int REG_SP   = 1;
    localparam int REG_DPTR = 2;
    localparam int REG_A    = 3;
    localparam int REG_VI   = 4;
    localparam int REG_TEMP = 5;
    localparam int REG_CTE1 = 6;
    localparam int REG_ACC  = 7;

endpackage

// File: rtl/pdua_alu.sv
// PDUA ALU, post-shifter, Bus C source mux and flag generation (combinational).
// Define PDUA_ROTATE_EN to make shamt=11 a rotate-right instead of an arithmetic shift.
module pdua_alu
    import pdua_pkg::*;
#(
    parameter int MAX_WIDTH = 8
) (
    input  logic [MAX_WIDTH-1:0] a,
    input  logic [MAX_WIDTH-1:0] b,
    input  logic [MAX_WIDTH-1:0] mdr,
    input  logic [2:0]           selop,
    input  logic [1:0]           shamt,
    input  logic                 mdr_alu_n,
    output logic [MAX_WIDTH-1:0] bus_c,
    output logic                 carry,
    output logic                 negative,
    output logic                 parity,
    output logic                 zero
);

    logic [MAX_WIDTH:0]   alu_wide;
    logic [MAX_WIDTH-1:0] alu_res;
    logic [MAX_WIDTH-1:0] shift_out;

    // The extra top bit of alu_wide is the carry; only ADD and INCB can set it.
    always_comb begin
        alu_wide = '0;
        case (alu_op_t'(selop))
            OP_PASSA: alu_wide = {1'b0, a};
            OP_PASSB: alu_wide = {1'b0, b};
            OP_AND:   alu_wide = {1'b0, a & b};
            OP_OR:    alu_wide = {1'b0, a | b};
            OP_XOR:   alu_wide = {1'b0, a ^ b};
            OP_ADD:   alu_wide = {1'b0, a} + {1'b0, b};
            OP_INCB:  alu_wide = {1'b0, b} + (MAX_WIDTH+1)'(1);
            OP_NOTA:  alu_wide = {1'b0, ~a};
            default:  alu_wide = '0;
        endcase
        alu_res = alu_wide[MAX_WIDTH-1:0];
        carry   = alu_wide[MAX_WIDTH];
    end

    always_comb begin
        shift_out = alu_res;
        case (shamt_t'(shamt))
            SH_NONE:    shift_out = alu_res;
            SH_LEFT:    shift_out = {alu_res[MAX_WIDTH-2:0], 1'b0};
            SH_RIGHT:   shift_out = {1'b0, alu_res[MAX_WIDTH-1:1]};
`ifdef PDUA_ROTATE_EN
            SH_SPECIAL: shift_out = {alu_res[0], alu_res[MAX_WIDTH-1:1]};
`else
            SH_SPECIAL: shift_out = {alu_res[MAX_WIDTH-1], alu_res[MAX_WIDTH-1:1]};
`endif
            default:    shift_out = alu_res;
        endcase
    end

    // Flags follow Bus C, so they reflect MDR when it is the selected source.
    always_comb begin
        bus_c    = mdr_alu_n ? mdr : shift_out;
        negative = bus_c[MAX_WIDTH-1];
        zero     = (bus_c == '0);
        parity   = ~(^bus_c);
    end

endmodule

// File: rtl/pdua_datapath.sv
// PDUA 8-bit datapath: register bank, ALU/shifter/flags, IR, MAR, MDR and data memory.
// Build with PDUA_ROTATE_EN defined to select rotate-right for shamt=11.
module pdua_datapath
    import pdua_pkg::*;
#(
    parameter int MAX_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_rdn,
    input  logic                  enaf,
    input  logic [2:0]            selop,
    input  logic [1:0]            shamt,
    output logic                  C,
    output logic                  N,
    output logic                  P,
    output logic                  Z,
    input  logic                  bank_wr_en,
    input  logic [ADDR_WIDTH-1:0] BusB_addr,
    input  logic [ADDR_WIDTH-1:0] BusC_addr,
    input  logic                  sclr,
    input  logic                  ir_en,
    input  logic                  mar_en,
    input  logic                  mdr_en,
    input  logic                  mdr_alu_n,
    output logic [4:0]            out_IR
);

    localparam int NUM_REGS  = 2**ADDR_WIDTH;
    localparam int MEM_DEPTH = 2**MAX_WIDTH;

    logic [MAX_WIDTH-1:0] bank_reg [NUM_REGS];
    logic [MAX_WIDTH-1:0] mem [MEM_DEPTH];
    logic [MAX_WIDTH-1:0] mar_reg;
    logic [MAX_WIDTH-1:0] mdr_reg;
    // Only the opcode field ever leaves the datapath, so only that part is held.
    logic [4:0]           ir_reg;
    logic                 flag_c_reg, flag_n_reg, flag_p_reg, flag_z_reg;

    logic [MAX_WIDTH-1:0] bus_a;
    logic [MAX_WIDTH-1:0] bus_b;
    logic [MAX_WIDTH-1:0] bus_c;
    logic [MAX_WIDTH-1:0] mem_rdata;
    logic                 alu_c, alu_n, alu_p, alu_z;

    assign bus_a     = bank_reg[REG_ACC];
    assign bus_b     = (BusB_addr == ADDR_WIDTH'(REG_CTE1)) ? MAX_WIDTH'(1) : bank_reg[BusB_addr];
    assign mem_rdata = mem[mar_reg];

    pdua_alu #(
        .MAX_WIDTH (MAX_WIDTH)
    ) u_alu (
        .a         (bus_a),
        .b         (bus_b),
        .mdr       (mdr_reg),
        .selop     (selop),
        .shamt     (shamt),
        .mdr_alu_n (mdr_alu_n),
        .bus_c     (bus_c),
        .carry     (alu_c),
        .negative  (alu_n),
        .parity    (alu_p),
        .zero      (alu_z)
    );

    // CTE1 is a read-only constant; its storage slot is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_reg[i] <= '0;
            end
        end else if (bank_wr_en && (BusC_addr != ADDR_WIDTH'(REG_CTE1))) begin
            bank_reg[BusC_addr] <= bus_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mar_reg    <= '0;
            mdr_reg    <= '0;
            ir_reg     <= '0;
            flag_c_reg <= 1'b0;
            flag_n_reg <= 1'b0;
            flag_p_reg <= 1'b0;
            flag_z_reg <= 1'b0;
        end else if (sclr) begin
            mar_reg    <= '0;
            mdr_reg    <= '0;
            ir_reg     <= '0;
            flag_c_reg <= 1'b0;
            flag_n_reg <= 1'b0;
            flag_p_reg <= 1'b0;
            flag_z_reg <= 1'b0;
        end else begin
            if (mar_en) begin
                mar_reg <= bus_c;
            end
            if (mdr_en) begin
                mdr_reg <= wr_rdn ? bus_c : mem_rdata;
            end
            if (ir_en) begin
                ir_reg <= mdr_reg[MAX_WIDTH-1 -: 5];
            end
            if (enaf) begin
                flag_c_reg <= alu_c;
                flag_n_reg <= alu_n;
                flag_p_reg <= alu_p;
                flag_z_reg <= alu_z;
            end
        end
    end

    // Memory keeps its contents across reset; a write needs wr_rdn with MDR not loading.
    always_ff @(posedge clk) begin
        if (wr_rdn && !mdr_en) begin
            mem[mar_reg] <= mdr_reg;
        end
    end

    assign C      = flag_c_reg;
    assign N      = flag_n_reg;
    assign P      = flag_p_reg;
    assign Z      = flag_z_reg;
    assign out_IR = ir_reg;

endmodule

// File: tb/tb_pdua_datapath.sv
// Self-checking bench for pdua_datapath: directed checks plus a reference-model
// scoreboard whose expected state is queued at drive time and popped after the edge.
module tb_pdua_datapath;

    typedef struct packed {
        logic [2:0] selop;
        logic [1:0] shamt;
        logic [2:0] busb;
        logic [2:0] busc;
        logic       bank_we;
        logic       enaf;
        logic       mdr_alu_n;
        logic       mar_en;
        logic       mdr_en;
        logic       wr_rdn;
        logic       ir_en;
        logic       sclr;
    } ctl_t;

    typedef struct packed {
        logic [7:0][7:0] bank;
        logic [7:0]      mar;
        logic [7:0]      mdr;
        logic [4:0]      ir;
        logic [3:0]      flags;
    } exp_t;

    logic       clk, rst;
    logic       wr_rdn, enaf, bank_wr_en, sclr, ir_en, mar_en, mdr_en, mdr_alu_n;
    logic [2:0] selop, BusB_addr, BusC_addr;
    logic [1:0] shamt;
    logic       C, N, P, Z;
    logic [4:0] out_IR;

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [7:0] m_bank [8];
    logic [7:0] m_mar, m_mdr;
    logic [4:0] m_ir;
    logic [3:0] m_flags;
    logic [7:0] m_mem [int];

    exp_t  exp_q [$];
    string tag_q [$];

    pdua_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .wr_rdn     (wr_rdn),
        .enaf       (enaf),
        .selop      (selop),
        .shamt      (shamt),
        .C          (C),
        .N          (N),
        .P          (P),
        .Z          (Z),
        .bank_wr_en (bank_wr_en),
        .BusB_addr  (BusB_addr),
        .BusC_addr  (BusC_addr),
        .sclr       (sclr),
        .ir_en      (ir_en),
        .mar_en     (mar_en),
        .mdr_en     (mdr_en),
        .mdr_alu_n  (mdr_alu_n),
        .out_IR     (out_IR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t alu_ctl(input logic [2:0] op, input logic [1:0] sh,
                                     input logic [2:0] bb, input logic [2:0] bc);
        ctl_t k = '0;
        k.selop   = op;
        k.shamt   = sh;
        k.busb    = bb;
        k.busc    = bc;
        k.bank_we = 1'b1;
        k.enaf    = 1'b1;
        return k;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
        m_mar = 8'h00; m_mdr = 8'h00; m_ir = 5'h00; m_flags = 4'h0;
    endtask

    task automatic push_state(input string tag);
        exp_t e;
        for (int i = 0; i < 8; i++) e.bank[i] = m_bank[i];
        e.mar = m_mar; e.mdr = m_mdr; e.ir = m_ir; e.flags = m_flags;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Reference model of one clock edge, computed from pre-edge state.
    task automatic model_step(input string tag, input ctl_t k);
        logic [7:0] a, b, r, sh, busc, old_mar, old_mdr;
        logic [8:0] w;
        a = m_bank[7];
        b = (k.busb == 3'd6) ? 8'h01 : m_bank[k.busb];
        case (k.selop)
            3'd0: w = {1'b0, a};
            3'd1: w = {1'b0, b};
            3'd2: w = {1'b0, a & b};
            3'd3: w = {1'b0, a | b};
            3'd4: w = {1'b0, a ^ b};
            3'd5: w = a + b;
            3'd6: w = b + 9'd1;
            default: w = {1'b0, ~a};
        endcase
        r = w[7:0];
        case (k.shamt)
            2'd0: sh = r;
            2'd1: sh = r << 1;
            2'd2: sh = r >> 1;
`ifdef PDUA_ROTATE_EN
            default: sh = {r[0], r[7:1]};
`else
            default: sh = $signed(r) >>> 1;
`endif
        endcase
        busc    = k.mdr_alu_n ? m_mdr : sh;
        old_mar = m_mar;
        old_mdr = m_mdr;
        if (k.wr_rdn && !k.mdr_en) m_mem[old_mar] = old_mdr;
        if (k.bank_we && k.busc != 3'd6) m_bank[k.busc] = busc;
        if (k.sclr) begin
            m_mar = 8'h00; m_mdr = 8'h00; m_ir = 5'h00; m_flags = 4'h0;
        end else begin
            if (k.mar_en) m_mar = busc;
            if (k.mdr_en) m_mdr = k.wr_rdn ? busc : m_mem[old_mar];
            if (k.ir_en)  m_ir = old_mdr[7:3];
            if (k.enaf)   m_flags = {w[8], busc[7], ($countones(busc) % 2 == 0), (busc == 8'h00)};
        end
        push_state(tag);
    endtask

    task automatic compare_head();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            if (i != 6) check_val($sformatf("%s.r%0d", t, i), dut.bank_reg[i], e.bank[i]);
        end
        check_val({t, ".mar"}, dut.mar_reg, e.mar);
        check_val({t, ".mdr"}, dut.mdr_reg, e.mdr);
        check_val({t, ".ir"}, out_IR, e.ir);
        check_val({t, ".flags"}, {C, N, P, Z}, e.flags);
    endtask

    task automatic drive(input ctl_t k);
        selop = k.selop; shamt = k.shamt; BusB_addr = k.busb; BusC_addr = k.busc;
        bank_wr_en = k.bank_we; enaf = k.enaf; mdr_alu_n = k.mdr_alu_n;
        mar_en = k.mar_en; mdr_en = k.mdr_en; wr_rdn = k.wr_rdn; ir_en = k.ir_en; sclr = k.sclr;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input string tag, input ctl_t k);
        drive(k);
        model_step(tag, k);
        @(posedge clk);
        #1;
        compare_head();
        $display("txn %-8s sel=%0d sh=%0d b=%0d c=%0d acc=%02h flags=%04b ir=%02h",
                 tag, k.selop, k.shamt, k.busb, k.busc, dut.bank_reg[7], {C, N, P, Z}, out_IR);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive('0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Builds a constant in ACC from zero using shift-left and OR-with-CTE1 steps.
    task automatic load_acc(input logic [7:0] v);
        cycle("clracc", alu_ctl(3'b100, 2'b00, 3'd7, 3'd7));
        for (int i = 7; i >= 0; i--) begin
            if (i != 7) cycle("shl", alu_ctl(3'b000, 2'b01, 3'd0, 3'd7));
            if (v[i])   cycle("or1", alu_ctl(3'b011, 2'b00, 3'd6, 3'd7));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctl_t k;
        drive('0);
        rst = 1'b1;
        model_reset();
        do_reset();

        // Reset state
        push_state("reset");
        compare_head();
        check_val("rst_acc", dut.bank_reg[7], 8'h00);
        check_val("rst_flags", {C, N, P, Z}, 4'h0);
        check_val("rst_ir", out_IR, 5'h00);

        // ACC <= CTE1
        cycle("ldcte1", alu_ctl(3'b001, 2'b00, 3'd6, 3'd7));
        check_val("t1_acc", dut.bank_reg[7], 8'h01);
        check_val("t1_flags", {C, N, P, Z}, 4'b0000);

        // AND after reset
        do_reset();
        cycle("and", alu_ctl(3'b010, 2'b00, 3'd3, 3'd7));
        check_val("t2_acc", dut.bank_reg[7], 8'h00);
        check_val("t2_flags", {C, N, P, Z}, 4'b0011);

        // Increment with carry
        cycle("nota", alu_ctl(3'b111, 2'b00, 3'd0, 3'd7));
        check_val("t3_ff", dut.bank_reg[7], 8'hFF);
        cycle("incb", alu_ctl(3'b110, 2'b00, 3'd7, 3'd7));
        check_val("t3_acc", dut.bank_reg[7], 8'h00);
        check_val("t3_flags", {C, N, P, Z}, 4'b1011);

        // Shifts into TEMP, ACC kept at the source value
        load_acc(8'h81);
        cycle("shl81", alu_ctl(3'b000, 2'b01, 3'd0, 3'd5));
        check_val("t4_shl", dut.bank_reg[5], 8'h02);
        cycle("shr81", alu_ctl(3'b000, 2'b10, 3'd0, 3'd5));
        check_val("t4_shr", dut.bank_reg[5], 8'h40);
        cycle("sh3_81", alu_ctl(3'b000, 2'b11, 3'd0, 3'd5));
        check_val("t4_sh3_81", dut.bank_reg[5], 8'hC0);
        load_acc(8'h02);
        cycle("sh3_02", alu_ctl(3'b000, 2'b11, 3'd0, 3'd5));
        check_val("t4_sh3_02", dut.bank_reg[5], 8'h01);

        // CTE1 ignores writes
        cycle("wrcte1", alu_ctl(3'b000, 2'b00, 3'd0, 3'd6));
        cycle("rdcte1", alu_ctl(3'b001, 2'b00, 3'd6, 3'd5));
        check_val("cte1_const", dut.bank_reg[5], 8'h01);

        // Memory round trip
        load_acc(8'h10);
        k = '0; k.mar_en = 1'b1;
        cycle("mar", k);
        check_val("t5_mar", dut.mar_reg, 8'h10);
        load_acc(8'hA5);
        k = '0; k.mdr_en = 1'b1; k.wr_rdn = 1'b1;
        cycle("mdrbusc", k);
        k = '0; k.wr_rdn = 1'b1;
        cycle("memwr", k);
        load_acc(8'h3C);
        k = '0; k.mdr_en = 1'b1; k.wr_rdn = 1'b1;
        cycle("mdr3c", k);
        check_val("t5_mdr3c", dut.mdr_reg, 8'h3C);
        k = '0; k.mdr_en = 1'b1;
        cycle("memrd", k);
        check_val("t5_mdr", dut.mdr_reg, 8'hA5);
        k = '0; k.ir_en = 1'b1;
        cycle("ir", k);
        check_val("t5_ir", out_IR, 5'h14);
        k = alu_ctl(3'b000, 2'b00, 3'd0, 3'd5); k.mdr_alu_n = 1'b1;
        cycle("mdrsrc", k);
        check_val("t5_mdrsrc", dut.bank_reg[5], 8'hA5);
        check_val("t5_mdrflags", {C, N, P, Z}, 4'b0110);

        // Synchronous clear
        load_acc(8'hFF);
        cycle("addcy", alu_ctl(3'b101, 2'b00, 3'd6, 3'd5));
        check_val("t6_preflags", {C, N, P, Z}, 4'b1011);
        k = alu_ctl(3'b110, 2'b00, 3'd7, 3'd7); k.bank_we = 1'b0; k.sclr = 1'b1;
        k.mar_en = 1'b1; k.mdr_en = 1'b1; k.ir_en = 1'b1;
        cycle("sclr", k);
        check_val("t6_flags", {C, N, P, Z}, 4'h0);
        check_val("t6_ir", out_IR, 5'h00);
        check_val("t6_mdr", dut.mdr_reg, 8'h00);
        check_val("t6_acc", dut.bank_reg[7], 8'hFF);

        // Asynchronous reset between edges
        cycle("setnp", alu_ctl(3'b000, 2'b00, 3'd0, 3'd5));
        drive('0);
        #2 rst = 1'b1;
        #1;
        check_val("t6_arst_acc", dut.bank_reg[7], 8'h00);
        check_val("t6_arst_temp", dut.bank_reg[5], 8'h00);
        check_val("t6_arst_flags", {C, N, P, Z}, 4'h0);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Random mixed traffic against the model
        for (int n = 0; n < 80; n++) begin
            k = ctl_t'($urandom);
            k.sclr = ($urandom_range(0, 9) == 0);
            if (k.mdr_en && !k.wr_rdn && !m_mem.exists(int'(m_mar))) k.wr_rdn = 1'b1;
            cycle($sformatf("rnd%0d", n), k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
